// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   - Load/store size codes carried on *_rd_wr (passed through untouched).
//   - arb_state_t: arbiter FSM state encoding.
package mem_arbiter_pkg;

  // Load/store size codes understood by the data memory.
  localparam logic [2:0] LB_SB = 3'b000;  // byte, sign-extended on load
  localparam logic [2:0] LH_SH = 3'b001;  // halfword, sign-extended on load
  localparam logic [2:0] LW_SW = 3'b010;  // word
  localparam logic [2:0] LBU   = 3'b100;  // byte, zero-extended
  localparam logic [2:0] LHU   = 3'b101;  // halfword, zero-extended

  // Requester identifiers.
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/arb_grant_pick.sv
// Grant selection for the two-requester memory arbiter.
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> on contention grant the requester not granted last
//     undefined -> on contention requester 0 always wins
//   A held lock masks out the non-owner before any arbitration.
// Ports:
//   valid       in  [1:0] request valid per requester
//   lock_active in        a lock is currently held
//   lock_owner  in        id of the lock holder
//   last_grant  in        id of the most recently accepted requester
//   grant       out [1:0] one-hot grant (all zero when nobody is eligible)
module arb_grant_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lock_active,
  input  logic       lock_owner,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic [1:0] eligible;

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    eligible = valid;
    if (lock_active) begin
      eligible = (lock_owner == REQ_ID1) ? (valid & 2'b10) : (valid & 2'b01);
    end

    grant = 2'b00;
    case (eligible)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
        grant = (last_grant == REQ_ID1) ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single data memory.
// Fixed three-cycle transaction: IDLE (accept) -> ACCESS (memory driven) -> RESP (pulse).
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin contention, see arb_grant_pick).
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   reqN_valid/ready             request handshake (ready combinational, IDLE only)
//   reqN_addr/wdata/rd_wr/wr     access description, latched on accept
//   reqN_lock                    keep exclusive ownership after this access
//   respN_valid/rdata            one-cycle completion pulse and load data (0 for stores)
//   mem_addr/wdata/rd_wr/wr      memory command, driven only in ACCESS
//   mem_rdata                    combinational memory read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 16,
  parameter int unsigned AW           = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [31:0]   req0_wdata,
  input  logic [2:0]    req0_rd_wr,
  input  logic          req0_wr,
  input  logic          req0_lock,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [31:0]   req1_wdata,
  input  logic [2:0]    req1_rd_wr,
  input  logic          req1_wr,
  input  logic          req1_lock,
  output logic          resp0_valid,
  output logic [31:0]   resp0_rdata,
  output logic          resp1_valid,
  output logic [31:0]   resp1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_rd_wr,
  output logic          mem_wr,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] ToLast = CW'(LOCK_TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic          owner_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    rd_wr_q;
  logic          wr_q;
  logic          lock_q, lock_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          last_grant_q;
  logic [31:0]   rdata_q;

  logic [1:0]    grant;
  logic          accept;
  logic          sel;
  logic          resp_active;

  arb_grant_pick u_grant_pick (
    .valid       ({req1_valid, req0_valid}),
    .lock_active (lock_q),
    .lock_owner  (owner_q),
    .last_grant  (last_grant_q),
    .grant       (grant)
  );

  // The pick only grants valid requesters, so a grant in IDLE is a handshake.
  assign accept = (state_q == StIdle) && (grant != 2'b00);
  assign sel    = grant[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Lock bookkeeping. An IDLE cycle with a lock held and no accept means the
  // owner was not requesting (the owner is always grantable while it holds the lock).
  always_comb begin
    lock_d   = lock_q;
    to_cnt_d = to_cnt_q;
    if (accept) begin
      lock_d   = sel ? req1_lock : req0_lock;
      to_cnt_d = '0;
    end else if ((state_q == StIdle) && lock_q) begin
      if (to_cnt_q == ToLast) begin
        lock_d   = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= REQ_ID0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_wr_q      <= '0;
      wr_q         <= 1'b0;
      lock_q       <= 1'b0;
      to_cnt_q     <= '0;
      last_grant_q <= REQ_ID1;
      rdata_q      <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      to_cnt_q <= to_cnt_d;
      if (accept) begin
        owner_q      <= sel;
        addr_q       <= sel ? req1_addr  : req0_addr;
        wdata_q      <= sel ? req1_wdata : req0_wdata;
        rd_wr_q      <= sel ? req1_rd_wr : req0_rd_wr;
        wr_q         <= sel ? req1_wr    : req0_wr;
        last_grant_q <= sel;
      end
      // Captured at the edge closing ACCESS, after the memory's negedge write.
      if (state_q == StAccess) begin
        rdata_q <= wr_q ? 32'h0 : mem_rdata;
      end
    end
  end

  // Handshake and command outputs are forced quiet in any cycle reset is high.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rd_wr   = '0;
    mem_wr      = 1'b0;
    resp_active = 1'b0;
    if (!reset) begin
      req0_ready  = (state_q == StIdle) && grant[0];
      req1_ready  = (state_q == StIdle) && grant[1];
      resp_active = (state_q == StResp);
      if (state_q == StAccess) begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd_wr = rd_wr_q;
        mem_wr    = wr_q;
      end
    end
    resp0_valid = resp_active && (owner_q == REQ_ID0);
    resp1_valid = resp_active && (owner_q == REQ_ID1);
    resp0_rdata = resp0_valid ? rdata_q : 32'h0;
    resp1_rdata = resp1_valid ? rdata_q : 32'h0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 16, consecutive IDLE cycles without owner request before a lock is forcibly released.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have, per requester N in {0,1}: reqN_valid in 1, reqN_ready out 1, reqN_addr in AW, reqN_wdata in 32, reqN_rd_wr in 3 (package load/store size code), reqN_wr in 1 (1 = store), reqN_lock in 1 (hold grant after this access).
REQ-006 SHALL have, per requester N: respN_valid out 1 (completion pulse), respN_rdata out 32 (load data; 0 for stores).
REQ-007 SHALL have memory-side ports mem_addr out AW, mem_wdata out 32, mem_rd_wr out 3, mem_wr out 1, mem_rdata in 32 (combinational read data from the data memory).

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-009 SHALL accept a request only in IDLE; reqN_ready is combinational, high only in IDLE for the granted requester with reqN_valid high; handshake = valid && ready.
REQ-010 SHALL latch addr, wdata, rd_wr, wr, lock and owner id on accept; requester inputs are don't-care afterwards.
REQ-011 SHALL drive mem_* from latched values only in ACCESS; mem_wr = latched wr in ACCESS, else 0; mem_addr, mem_wdata, mem_rd_wr = 0 outside ACCESS.
REQ-012 SHALL register mem_rdata at the posedge ending ACCESS (after the memory's negedge write completes); for stores the register SHALL load 0.
REQ-013 SHALL assert respN_valid for exactly the RESP cycle, only for the owner; respN_rdata holds the registered value while respN_valid is high, 0 otherwise.
REQ-014 Latency SHALL be fixed: accept at cycle T, memory access T+1, response T+2; next accept no earlier than T+3.
REQ-015 Arbitration when both valid and no lock: per Configuration; when one valid, that one wins.
REQ-016 Lock: an accepted request with lock=1 SHALL make its owner exclusive; in IDLE only the owner may be granted; other requester's ready stays 0.
REQ-017 Lock SHALL release when the owner's accepted request has lock=0, or when the owner's valid stays low for LOCK_TIMEOUT consecutive IDLE cycles (counter clears on any owner accept).
REQ-018 Addresses SHALL pass unmodified; address 0 and misalignment are not checked (memory defines the outcome); the response is still issued.
REQ-019 Out-of-range rd_wr codes SHALL pass through unchanged.

Reset
REQ-020 On reset: state IDLE, lock cleared, timeout counter 0, last-grant = 1, response data 0; all ready, resp_valid, mem_wr outputs 0 in the same cycle reset is sampled.
REQ-021 Reset in ACCESS or RESP SHALL abort the transaction; no response pulse is issued afterwards.

Configuration
REQ-022 With ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester not granted last (last-grant updated on every accept); without it, requester 0 SHALL always win contention.

Structure
REQ-023 The shared package SHALL hold the FSM state enum type arb_state_t alongside the existing load/store size codes.
REQ-024 Grant selection (priority/round-robin/lock masking) SHALL live in sub-module arb_grant_pick; FSM, latches and timeout counter in mem_arbiter.

Verification
REQ-025 Single store: req0 addr 0x10, wdata 0xDEADBEEF, LW_SW, wr=1 -> ready0 at T, mem_wr=1 at T+1, resp0_valid at T+2 with rdata 0.
REQ-026 Load after store: req1 load LW_SW addr 0x10 -> resp1_rdata 0xDEADBEEF at T+2; LB_SB addr 0x13 -> 0xFFFFFFDE.
REQ-027 Contention with ARB_ROUND_ROBIN_EN: both valid continuously for 4 accepts -> grants 0,1,0,1; without macro -> 0,0,0,0.
REQ-028 Lock: req0 lock=1 accepted, req1 valid held -> req1 ready 0 until req0 issues lock=0 access; then req1 granted next IDLE.
REQ-029 Lock timeout: req0 lock=1 then req0 valid low, req1 valid -> req1 granted after exactly 16 IDLE cycles.
REQ-030 Reset in ACCESS during a store: no resp pulse, state IDLE next cycle, both readies low while reset high.
